// File: rtl/hawk_cpu_stall_rd_q.sv
// hawk_cpu_stall_rd_q: CPU read-stall bridge on the AXI4 AR channel.
// Queues up to DEPTH read requests, sends a tagged page lookup per entry to the hawk
// control unit (results may come back out of order) and reissues requests to memory
// strictly in arrival order using the translated page. With hawk inactive and nothing
// queued, AR is bypassed combinationally. The R channel is a pure pass-through.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   hawk_inactive       hawk disabled: bypass when empty, drain otherwise
//   s_axi_ar*           CPU read-address channel (slave side)
//   m_axi_ar*           memory read-address channel (master side)
//   s_axi_r* / m_axi_r* read-data channel, passed straight through
//   lkup_*              page lookup request to hawk (tag = queue entry index)
//   ovrd_*              lookup result from hawk
//   q_count             queue occupancy 0..DEPTH
//   err_sticky          result seen for an entry not awaiting one
module hawk_cpu_stall_rd_q #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 6,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PAGE_SHIFT = 12,
    parameter int unsigned TAG_W      = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           hawk_inactive,
    input  logic [ID_WIDTH-1:0]            s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic [7:0]                     s_axi_arlen,
    input  logic [2:0]                     s_axi_arsize,
    input  logic [1:0]                     s_axi_arburst,
    input  logic [USER_WIDTH-1:0]          s_axi_aruser,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [ID_WIDTH-1:0]            m_axi_arid,
    output logic [ADDR_WIDTH-1:0]          m_axi_araddr,
    output logic [7:0]                     m_axi_arlen,
    output logic [2:0]                     m_axi_arsize,
    output logic [1:0]                     m_axi_arburst,
    output logic [USER_WIDTH-1:0]          m_axi_aruser,
    output logic                           m_axi_arvalid,
    input  logic                           m_axi_arready,
    output logic [ID_WIDTH-1:0]            s_axi_rid,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rlast,
    output logic [USER_WIDTH-1:0]          s_axi_ruser,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    input  logic [ID_WIDTH-1:0]            m_axi_rid,
    input  logic [DATA_WIDTH-1:0]          m_axi_rdata,
    input  logic [1:0]                     m_axi_rresp,
    input  logic                           m_axi_rlast,
    input  logic [USER_WIDTH-1:0]          m_axi_ruser,
    input  logic                           m_axi_rvalid,
    output logic                           m_axi_rready,
    output logic                           lkup_valid,
    input  logic                           lkup_ready,
    output logic [ADDR_WIDTH-PAGE_SHIFT-1:0] lkup_hppa,
    output logic [TAG_W-1:0]               lkup_tag,
    input  logic                           ovrd_valid,
    input  logic [TAG_W-1:0]               ovrd_tag,
    input  logic [ADDR_WIDTH-PAGE_SHIFT-1:0] ovrd_ppa,
    output logic [TAG_W:0]                 q_count,
    output logic                           err_sticky
);

    localparam int unsigned PPN_W = ADDR_WIDTH - PAGE_SHIFT;

    typedef enum logic [1:0] {StFree, StPend, StLkup, StXlat} ent_st_e;

    ent_st_e                 st_q    [DEPTH];
    logic [ID_WIDTH-1:0]     id_q    [DEPTH];
    logic [ADDR_WIDTH-1:0]   addr_q  [DEPTH];
    logic [7:0]              len_q   [DEPTH];
    logic [2:0]              size_q  [DEPTH];
    logic [1:0]              burst_q [DEPTH];
    logic [USER_WIDTH-1:0]   user_q  [DEPTH];
    logic [PPN_W-1:0]        ppa_q   [DEPTH];

    logic [TAG_W-1:0] head_q, tail_q, lkup_tag_q, pend_idx, scan_idx;
    logic [TAG_W:0]   count_q;
    logic             init_q, arvalid_q, lkup_valid_q, err_q;
    logic             bypass, accept, free, lkup_hs, ovrd_hit, pend_found, head_will_xlat;

    // R channel is untouched.
    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rlast  = m_axi_rlast;
    assign s_axi_ruser  = m_axi_ruser;
    assign s_axi_rvalid = m_axi_rvalid;
    assign m_axi_rready = s_axi_rready;

    // init_q keeps arready low while in reset and bypass disabled until the first clock.
    assign bypass   = init_q & hawk_inactive & (count_q == '0) & ~arvalid_q;
    assign accept   = ~bypass & init_q & s_axi_arvalid & (count_q < (TAG_W+1)'(DEPTH));
    assign free     = arvalid_q & m_axi_arready;
    assign lkup_hs  = lkup_valid_q & lkup_ready;
    // A result may land in the same cycle as its own lookup handshake.
    assign ovrd_hit = ovrd_valid &
                      ((st_q[ovrd_tag] == StLkup) | (lkup_hs & (lkup_tag_q == ovrd_tag)));

    always_comb begin
        // Oldest PEND entry, skipping one that is being handshaken this cycle.
        pend_found = 1'b0;
        pend_idx   = '0;
        scan_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + TAG_W'(i);
            if (!pend_found && st_q[scan_idx] == StPend &&
                !(lkup_hs && scan_idx == lkup_tag_q)) begin
                pend_found = 1'b1;
                pend_idx   = scan_idx;
            end
        end
        // Head reaches XLAT at this edge: gives the 1-cycle ovrd-to-arvalid latency.
        head_will_xlat = (st_q[head_q] == StXlat) |
                         (ovrd_hit & (ovrd_tag == head_q)) |
                         (hawk_inactive & (st_q[head_q] == StPend) &
                          ~(lkup_hs & (lkup_tag_q == head_q)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]    <= StFree;
                id_q[i]    <= '0;
                addr_q[i]  <= '0;
                len_q[i]   <= '0;
                size_q[i]  <= '0;
                burst_q[i] <= '0;
                user_q[i]  <= '0;
                ppa_q[i]   <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            init_q       <= 1'b0;
            arvalid_q    <= 1'b0;
            lkup_valid_q <= 1'b0;
            lkup_tag_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            init_q <= 1'b1;
            if (accept) begin
                st_q[tail_q]    <= StPend;
                id_q[tail_q]    <= s_axi_arid;
                addr_q[tail_q]  <= s_axi_araddr;
                len_q[tail_q]   <= s_axi_arlen;
                size_q[tail_q]  <= s_axi_arsize;
                burst_q[tail_q] <= s_axi_arburst;
                user_q[tail_q]  <= s_axi_aruser;
                tail_q          <= tail_q + 1'b1;
            end
            // Drain: PEND entries keep their own page, no lookup needed.
            if (hawk_inactive) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (st_q[i] == StPend) begin
                        st_q[i]  <= StXlat;
                        ppa_q[i] <= addr_q[i][ADDR_WIDTH-1:PAGE_SHIFT];
                    end
                end
            end
            // Later assignments win: handshake over drain, result over handshake.
            if (lkup_hs) st_q[lkup_tag_q] <= StLkup;
            if (ovrd_hit) begin
                st_q[ovrd_tag]  <= StXlat;
                ppa_q[ovrd_tag] <= ovrd_ppa;
            end else if (ovrd_valid) begin
                err_q <= 1'b1;
            end
            if (free) begin
                st_q[head_q] <= StFree;
                head_q       <= head_q + 1'b1;
            end
            if (accept && !free) count_q <= count_q + 1'b1;
            else if (free && !accept) count_q <= count_q - 1'b1;

            if (hawk_inactive) begin
                lkup_valid_q <= 1'b0;
            end else if (!lkup_valid_q || lkup_ready) begin
                lkup_valid_q <= pend_found;
                if (pend_found) lkup_tag_q <= pend_idx;
            end

            if (arvalid_q) begin
                if (m_axi_arready) arvalid_q <= 1'b0;
            end else begin
                arvalid_q <= head_will_xlat;
            end
        end
    end

    always_comb begin
        if (bypass) begin
            m_axi_arid    = s_axi_arid;
            m_axi_araddr  = s_axi_araddr;
            m_axi_arlen   = s_axi_arlen;
            m_axi_arsize  = s_axi_arsize;
            m_axi_arburst = s_axi_arburst;
            m_axi_aruser  = s_axi_aruser;
            m_axi_arvalid = s_axi_arvalid;
            s_axi_arready = m_axi_arready;
        end else begin
            m_axi_arid    = id_q[head_q];
            m_axi_araddr  = {ppa_q[head_q], addr_q[head_q][PAGE_SHIFT-1:0]};
            m_axi_arlen   = len_q[head_q];
            m_axi_arsize  = size_q[head_q];
            m_axi_arburst = burst_q[head_q];
            m_axi_aruser  = user_q[head_q];
            m_axi_arvalid = arvalid_q;
            s_axi_arready = init_q & (count_q < (TAG_W+1)'(DEPTH));
        end
    end

    assign lkup_valid = lkup_valid_q;
    assign lkup_tag   = lkup_tag_q;
    assign lkup_hppa  = addr_q[lkup_tag_q][ADDR_WIDTH-1:PAGE_SHIFT];
    assign q_count    = count_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_hawk_cpu_stall_rd_q.sv
module tb_hawk_cpu_stall_rd_q;

    localparam int unsigned DW = 512, AW = 64, IW = 6, UW = 1, TW = 2, PW = 52;

    logic clk = 1'b0;
    logic rst_n, hawk_inactive;
    logic [IW-1:0] s_axi_arid, m_axi_arid, s_axi_rid, m_axi_rid;
    logic [AW-1:0] s_axi_araddr, m_axi_araddr;
    logic [7:0] s_axi_arlen, m_axi_arlen;
    logic [2:0] s_axi_arsize, m_axi_arsize;
    logic [1:0] s_axi_arburst, m_axi_arburst, s_axi_rresp, m_axi_rresp;
    logic [UW-1:0] s_axi_aruser, m_axi_aruser, s_axi_ruser, m_axi_ruser;
    logic s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
    logic [DW-1:0] s_axi_rdata, m_axi_rdata;
    logic s_axi_rlast, m_axi_rlast, s_axi_rvalid, m_axi_rvalid, s_axi_rready, m_axi_rready;
    logic lkup_valid, lkup_ready, ovrd_valid, err_sticky;
    logic [PW-1:0] lkup_hppa, ovrd_ppa;
    logic [TW-1:0] lkup_tag, ovrd_tag;
    logic [TW:0] q_count;

    int n_vec = 0;
    int n_err = 0;

    hawk_cpu_stall_rd_q dut (
        .clk(clk), .rst_n(rst_n), .hawk_inactive(hawk_inactive),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_aruser(s_axi_aruser), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_aruser(m_axi_aruser), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .lkup_valid(lkup_valid), .lkup_ready(lkup_ready), .lkup_hppa(lkup_hppa),
        .lkup_tag(lkup_tag), .ovrd_valid(ovrd_valid), .ovrd_tag(ovrd_tag),
        .ovrd_ppa(ovrd_ppa), .q_count(q_count), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ar(input logic [63:0] a, input logic [IW-1:0] id);
        s_axi_araddr  = a;
        s_axi_arid    = id;
        s_axi_arvalid = 1'b1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int ord[4];
        int wt[4];
        logic [63:0] wh[4];
        rst_n = 1'b0; hawk_inactive = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd6;
        s_axi_arburst = 2'd1; s_axi_aruser = '0; s_axi_arvalid = 1'b0;
        m_axi_arready = 1'b0; s_axi_rready = 1'b0;
        m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0;
        m_axi_ruser = '0; m_axi_rvalid = 1'b0;
        lkup_ready = 1'b0; ovrd_valid = 1'b0; ovrd_tag = '0; ovrd_ppa = '0;

        // Reset state
        #2;
        check("rst_arready", s_axi_arready, 0);
        check("rst_qcount", q_count, 0);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_lkup", lkup_valid, 0);
        check("rst_err", err_sticky, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_arready", s_axi_arready, 1);

        // R pass-through
        m_axi_rvalid = 1'b1; m_axi_rdata = {8{64'h0123_4567_89AB_CDEF}}; s_axi_rready = 1'b1;
        #1;
        check("r_valid", s_axi_rvalid, 1);
        check("r_data", s_axi_rdata[63:0], 64'h0123_4567_89AB_CDEF);
        check("r_ready", m_axi_rready, 1);
        m_axi_rvalid = 1'b0; s_axi_rready = 1'b0;

        // Bypass
        hawk_inactive = 1'b1;
        drive_ar(64'h8000_1234, 6'd1);
        #1;
        check("byp_addr", m_axi_araddr, 64'h8000_1234);
        check("byp_vld", m_axi_arvalid, 1);
        check("byp_rdy0", s_axi_arready, 0);
        m_axi_arready = 1'b1;
        #1;
        check("byp_rdy1", s_axi_arready, 1);
        tick();
        check("byp_cnt", q_count, 0);
        s_axi_arvalid = 1'b0; m_axi_arready = 1'b0; hawk_inactive = 1'b0;

        // Single translate
        drive_ar(64'h0000_5ABC, 6'd3);
        s_axi_arlen = 8'd7;
        #1;
        check("tr_acc_rdy", s_axi_arready, 1);
        check("tr_no_byp", m_axi_arvalid, 0);
        tick();
        s_axi_arvalid = 1'b0;
        check("tr_cnt", q_count, 1);
        check("tr_lkup_lat", lkup_valid, 0);
        tick();
        check("tr_lkup_vld", lkup_valid, 1);
        check("tr_lkup_tag", lkup_tag, 0);
        check("tr_lkup_hppa", lkup_hppa, 64'h5);
        lkup_ready = 1'b1;
        tick();
        lkup_ready = 1'b0;
        check("tr_lkup_done", lkup_valid, 0);
        check("tr_wait", m_axi_arvalid, 0);
        ovrd_valid = 1'b1; ovrd_tag = 2'd0; ovrd_ppa = 52'h9_0000;
        tick();
        ovrd_valid = 1'b0;
        check("tr_arvalid", m_axi_arvalid, 1);
        check("tr_addr", m_axi_araddr, 64'h9000_0ABC);
        check("tr_id", m_axi_arid, 3);
        check("tr_len", m_axi_arlen, 7);
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        check("tr_free_cnt", q_count, 0);
        check("tr_free_vld", m_axi_arvalid, 0);
        s_axi_arlen = 8'd0;

        // Out-of-order results, full queue
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            drive_ar((64'(i + 1) << 12) | 64'(12'h100 + i), IW'(i));
            tick();
        end
        check("ooo_full_cnt", q_count, 4);
        check("ooo_full_rdy", s_axi_arready, 0);
        tick();
        s_axi_arvalid = 1'b0;
        check("ooo_full_hold", q_count, 4);
        lkup_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ooo_lkup_vld", lkup_valid, 1);
            check("ooo_lkup_tag", lkup_tag, 64'(i));
            check("ooo_lkup_hppa", lkup_hppa, 64'(i + 1));
            tick();
        end
        lkup_ready = 1'b0;
        check("ooo_lkup_idle", lkup_valid, 0);
        ord = '{3, 1, 2, 0};
        for (int k = 0; k < 4; k++) begin
            ovrd_valid = 1'b1; ovrd_tag = TW'(ord[k]); ovrd_ppa = PW'(32'h100 + ord[k]);
            tick();
            ovrd_valid = 1'b0;
            check("ooo_order_hold", m_axi_arvalid, 64'(k == 3));
        end
        m_axi_arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < 4 && !m_axi_arvalid; w++) tick();
            check("ooo_issue_vld", m_axi_arvalid, 1);
            check("ooo_issue_addr", m_axi_araddr, (64'(32'h100 + i) << 12) | 64'(32'h100 + i));
            check("ooo_issue_id", m_axi_arid, 64'(i));
            tick();
        end
        m_axi_arready = 1'b0;
        check("ooo_empty", q_count, 0);

        // Full queue, free one, wrap into slot 0
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            drive_ar(64'(32'h20 + i) << 12, IW'(i));
            tick();
        end
        s_axi_arvalid = 1'b0;
        check("wrap_full_cnt", q_count, 4);
        check("wrap_full_rdy", s_axi_arready, 0);
        lkup_ready = 1'b1;
        tick();
        lkup_ready = 1'b0;
        ovrd_valid = 1'b1; ovrd_tag = 2'd0; ovrd_ppa = 52'h777;
        tick();
        ovrd_valid = 1'b0;
        check("wrap_issue_vld", m_axi_arvalid, 1);
        check("wrap_issue_addr", m_axi_araddr, 64'h77_7000);
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        check("wrap_cnt3", q_count, 3);
        check("wrap_rdy", s_axi_arready, 1);
        drive_ar(64'hAB_005, 6'd9);
        tick();
        s_axi_arvalid = 1'b0;
        check("wrap_cnt4", q_count, 4);
        wt = '{1, 2, 3, 0};
        wh = '{64'h21, 64'h22, 64'h23, 64'hAB};
        lkup_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("wrap_lkup_tag", lkup_tag, 64'(wt[i]));
            check("wrap_lkup_hppa", lkup_hppa, wh[i]);
            tick();
        end
        lkup_ready = 1'b0;

        // Drain
        pulse_reset();
        drive_ar(64'h11_022, 6'd4);
        tick();
        drive_ar(64'h33_044, 6'd5);
        tick();
        s_axi_arvalid = 1'b0;
        check("drn_lkup_tag0", lkup_tag, 0);
        lkup_ready = 1'b1;
        tick();
        lkup_ready = 1'b0;
        hawk_inactive = 1'b1;
        check("drn_lkup_tag1", lkup_tag, 1);
        tick();
        check("drn_withdrawn", lkup_valid, 0);
        check("drn_cnt", q_count, 2);
        check("drn_wait0", m_axi_arvalid, 0);
        tick();
        check("drn_wait1", m_axi_arvalid, 0);
        ovrd_valid = 1'b1; ovrd_tag = 2'd0; ovrd_ppa = 52'h55;
        tick();
        ovrd_valid = 1'b0;
        check("drn_a_vld", m_axi_arvalid, 1);
        check("drn_a_addr", m_axi_araddr, 64'h55_022);
        m_axi_arready = 1'b1;
        tick();
        check("drn_gap", m_axi_arvalid, 0);
        tick();
        check("drn_b_vld", m_axi_arvalid, 1);
        check("drn_b_addr", m_axi_araddr, 64'h33_044);
        check("drn_b_id", m_axi_arid, 5);
        tick();
        check("drn_empty", q_count, 0);
        drive_ar(64'h8000_1234, 6'd2);
        #1;
        check("drn_byp_addr", m_axi_araddr, 64'h8000_1234);
        check("drn_byp_rdy", s_axi_arready, 1);
        s_axi_arvalid = 1'b0; m_axi_arready = 1'b0; hawk_inactive = 1'b0;

        // Error and mid-queue reset
        pulse_reset();
        ovrd_valid = 1'b1; ovrd_tag = 2'd2; ovrd_ppa = 52'h1;
        tick();
        ovrd_valid = 1'b0;
        check("err_set", err_sticky, 1);
        check("err_cnt", q_count, 0);
        check("err_vld", m_axi_arvalid, 0);
        drive_ar(64'h4_000, 6'd0);
        tick();
        tick();
        s_axi_arvalid = 1'b0;
        tick();
        check("mid_cnt", q_count, 2);
        check("mid_lkup", lkup_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", q_count, 0);
        check("mid_rst_vld", m_axi_arvalid, 0);
        check("mid_rst_lkup", lkup_valid, 0);
        check("mid_rst_err", err_sticky, 0);
        check("mid_rst_rdy", s_axi_arready, 0);
        rst_n = 1'b1;
        tick();
        check("mid_rel_rdy", s_axi_arready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hawk_cpu_stall_rd_q.md
Name: hawk_cpu_stall_rd_q

Overview:
Next-generation CPU read-stall bridge between the CPU AXI4 read-address channel and memory. It buffers up to DEPTH read requests in a queue. Each request gets a page lookup to the hawk control unit, tagged so several lookups can be outstanding and can return out of order. Requests are reissued to the master port strictly in arrival order, with the translated page address. When hawk is inactive and the queue is empty, the AR channel is bypassed combinationally.

Parameters:
DATA_WIDTH, 512, AXI data width
ADDR_WIDTH, 64, AXI address width
ID_WIDTH, 6, AXI ID width
USER_WIDTH, 1, aruser/ruser width
DEPTH, 4, queue entries; power of 2, at least 2
PAGE_SHIFT, 12, page offset bits kept from the CPU address
TAG_W, $clog2(DEPTH), lookup tag width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
hawk_inactive  in  1  hawk disabled; enables bypass and drain mode
s_axi_ar{id,addr,len,size,burst,user}  in  ID/ADDR/8/3/2/USER  CPU read-address fields
s_axi_arvalid  in  1  CPU request valid
s_axi_arready  out  1  bridge accepts the CPU request
m_axi_ar{id,addr,len,size,burst,user}  out  same widths  memory read-address fields
m_axi_arvalid  out  1  memory request valid
m_axi_arready  in  1  memory accepts the request
s_axi_r*/m_axi_r*  in/out  per AXI  R channel: combinational pass-through; m_axi_rready = s_axi_rready
lkup_valid  out  1  lookup request to hawk
lkup_ready  in  1  hawk accepts the lookup
lkup_hppa  out  ADDR_WIDTH-PAGE_SHIFT  CPU page number
lkup_tag  out  TAG_W  index of the queue entry
ovrd_valid  in  1  lookup result valid
ovrd_tag  in  TAG_W  entry the result belongs to
ovrd_ppa  in  ADDR_WIDTH-PAGE_SHIFT  translated page number
q_count  out  TAG_W+1  current queue occupancy
err_sticky  out  1  result arrived for an entry not in LKUP state

Behaviour:
- Each entry is in one of four states: FREE -> PEND -> LKUP -> XLAT -> FREE.
- Head and tail pointers are TAG_W bits and wrap modulo DEPTH. q_count is 0..DEPTH.
- Reset (asynchronous, rst_n=0): all entries FREE; pointers 0; q_count=0; m_axi_arvalid=0; lkup_valid=0; err_sticky=0. s_axi_arready=0 during reset and 1 from the first clock after release.
- Bypass is active when hawk_inactive=1, q_count=0 and no registered m_axi_arvalid is pending.
  - In bypass, all m_axi_ar* = s_axi_ar*, m_axi_arvalid = s_axi_arvalid and s_axi_arready = m_axi_arready. Zero latency; nothing is queued.
- Accept (queue mode): s_axi_arready = (q_count < DEPTH), derived from registered state only.
  - On handshake, the tail entry captures all AR fields and goes to PEND; tail advances.
- Lookup issue:
  - lkup_valid is registered. It presents the oldest PEND entry (search from head) and goes high one cycle after that entry is allocated.
  - On lkup_valid & lkup_ready, that entry moves PEND -> LKUP. Up to DEPTH lookups may be outstanding.
  - lkup_valid/lkup_tag/lkup_hppa hold stable until the handshake.
- Result:
  - ovrd_valid with ovrd_tag pointing at a LKUP entry: store ovrd_ppa, entry goes to XLAT.
  - A result may arrive in the same cycle as that entry's lookup handshake, but not earlier.
  - ovrd_valid on a non-LKUP entry is ignored and sets err_sticky (cleared only by reset).
- Drain mode (hawk_inactive=1 with q_count>0):
  - PEND entries go straight to XLAT with ppa equal to their own CPU page; no lookup is issued.
  - LKUP entries still wait for their ovrd result.
  - A lookup already presented but not yet handshaken is withdrawn.
- Issue to master:
  - When the head entry is XLAT and no m_axi_arvalid is pending, register m_axi_arvalid=1 on the next cycle.
  - m_axi_araddr = {ppa, cpu_addr[PAGE_SHIFT-1:0]}; the other fields are as captured.
  - On m_axi_arready, the entry is freed, head advances and q_count decrements.
  - Latency from ovrd_valid on the head entry to m_axi_arvalid is 1 cycle.
  - Issue is strictly in order: a younger XLAT entry waits behind an older LKUP entry.
- Simultaneous accept and free: q_count is unchanged. Accept is never blocked by a same-cycle free, because arready is registered-full based.
- Reset mid-operation discards all queued entries and in-flight lookups. Hawk must also reset its lookup state.
- The R channel is untouched; read responses may return out of order by ID.

Test Plan:
- Bypass: hawk_inactive=1, queue empty, CPU araddr=0x8000_1234 -> m_axi_araddr=0x8000_1234 in the same cycle; s_axi_arready follows m_axi_arready.
- Single translate: hawk_inactive=0, araddr=0x0000_5ABC; lkup_hppa=0x5; ovrd_ppa=0x9_0000 -> m_axi_araddr=0x9000_0ABC, m_axi_arvalid high one cycle after ovrd_valid.
- Out-of-order results: 4 requests (tags 0-3), ovrd returned in order 3,1,2,0 -> m_axi_arvalid issued in order 0,1,2,3, each with its own ppa.
- Full queue: 4 accepted with no ovrd -> s_axi_arready=0 and q_count=4. Returning tag 0 and freeing it via m_axi_arready -> arready=1 the next cycle; a new request lands in slot 0 (wrap).
- Drain: 2 entries, one LKUP and one PEND; assert hawk_inactive -> PEND entry issues with its untranslated address only after the LKUP entry's ovrd; bypass resumes once q_count=0.
- Error and reset: ovrd_valid to a FREE tag -> err_sticky=1 and no state change. Assert rst_n=0 mid-queue -> q_count=0, arvalid=0, lkup_valid=0, err_sticky=0 immediately.
